// File: rtl/uart_frame_receiver.sv
// Framed command receiver: hunts for a sync word, collects NUM_WORDS payload words,
// verifies a modular-sum checksum and presents the payload as one word with a valid pulse.
module uart_frame_receiver #(
    parameter int               WIDTH         = 8,
    parameter int               NUM_WORDS     = 6,
    parameter logic [WIDTH-1:0] SYNC_WORD     = 'hA5,
    parameter bit               LITTLE_ENDIAN = 1'b0,
    parameter int               TIMEOUT       = 100000
) (
    input  logic                       clk,
    input  logic                       i_reset,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_dv,
    output logic [WIDTH*NUM_WORDS-1:0] o_data,
    output logic                       o_dv,
    output logic                       o_err_checksum,
    output logic                       o_err_timeout,
    output logic                       o_busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK
    } state_t;

    state_t                     state;
    logic                       dv_q;
    logic [IW-1:0]              idx;
    logic [WIDTH-1:0]           sum;
    logic [TW-1:0]              timer;
    logic [WIDTH-1:0]           shadow [NUM_WORDS];
    logic [WIDTH*NUM_WORDS-1:0] frame_word;

    logic                       accept;
    logic                       expire;
    logic [TW-1:0]              timer_nxt;

    function automatic logic [WIDTH-1:0] sum_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    // One acceptance per i_dv high period; a word arriving on the expiry cycle wins.
    always_comb begin
        accept    = i_dv & ~dv_q;
        timer_nxt = timer + 1'b1;
        expire    = ~accept & (state != S_IDLE) & (timer_nxt == TIMER_LAST);
    end

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_slot
        localparam int LSB = LITTLE_ENDIAN ? k * WIDTH : (NUM_WORDS - 1 - k) * WIDTH;
        assign frame_word[LSB +: WIDTH] = shadow[k];
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state          <= S_IDLE;
            dv_q           <= 1'b0;
            idx            <= '0;
            sum            <= '0;
            timer          <= '0;
            o_data         <= '0;
            o_dv           <= 1'b0;
            o_err_checksum <= 1'b0;
            o_err_timeout  <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            dv_q           <= i_dv;
            o_dv           <= 1'b0;
            o_err_checksum <= 1'b0;
            o_err_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && i_data == SYNC_WORD) begin
                        state  <= S_PAYLOAD;
                        o_busy <= 1'b1;
                        idx    <= '0;
                        sum    <= '0;
                        timer  <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        shadow[idx] <= i_data;
                        sum         <= sum_add(sum, i_data);
                        timer       <= '0;
                        if (idx == IDX_LAST) begin
                            state <= S_CHECK;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (expire) begin
                        state         <= S_IDLE;
                        o_busy        <= 1'b0;
                        o_err_timeout <= 1'b1;
                        timer         <= '0;
                    end else begin
                        timer <= timer_nxt;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (i_data == sum) begin
                            o_data <= frame_word;
                            o_dv   <= 1'b1;
                        end else begin
                            o_err_checksum <= 1'b1;
                        end
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        timer  <= '0;
                    end else if (expire) begin
                        state         <= S_IDLE;
                        o_busy        <= 1'b0;
                        o_err_timeout <= 1'b1;
                        timer         <= '0;
                    end else begin
                        timer <= timer_nxt;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Scoreboard bench for uart_frame_receiver: two instances (big-endian/TIMEOUT=50 and
// little-endian/TIMEOUT=1000) share one stimulus stream and a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_frame_receiver;

    localparam int K_DV = 1;
    localparam int K_CK = 2;
    localparam int K_TO = 3;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          kind;
        longint      cyc;
        logic [47:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_data = '0;
    logic        i_dv = 1'b0;
    logic [47:0] o_data0, o_data1;
    logic        o_dv0, o_dv1, o_ck0, o_ck1, o_to0, o_to1, o_busy0, o_busy1;

    always #5 clk = ~clk;

    uart_frame_receiver #(.WIDTH(8), .NUM_WORDS(6), .SYNC_WORD(8'hA5),
                          .LITTLE_ENDIAN(1'b0), .TIMEOUT(50)) u0 (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
        .o_data(o_data0), .o_dv(o_dv0), .o_err_checksum(o_ck0),
        .o_err_timeout(o_to0), .o_busy(o_busy0));

    uart_frame_receiver #(.WIDTH(8), .NUM_WORDS(6), .SYNC_WORD(8'hA5),
                          .LITTLE_ENDIAN(1'b1), .TIMEOUT(1000)) u1 (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
        .o_data(o_data1), .o_dv(o_dv1), .o_err_checksum(o_ck1),
        .o_err_timeout(o_to1), .o_busy(o_busy1));

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, one set per instance
    int          to_lim [2] = '{50, 1000};
    bit          le     [2] = '{1'b0, 1'b1};
    bit          in_frame [2];
    int          fcnt     [2];
    logic [7:0]  fw       [2][6];
    longint      last_c   [2];
    logic [47:0] good     [2];

    function automatic void push_exp(input int d, input int kind, input longint c,
                                     input logic [47:0] data);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = data;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void m_flush(input int d, input longint c);
        longint t_edge;
        t_edge = last_c[d] + longint'(to_lim[d]) - 1;
        if (in_frame[d] && t_edge <= c) begin
            push_exp(d, K_TO, t_edge, good[d]);
            in_frame[d] = 1'b0;
        end
    endfunction

    function automatic logic [47:0] pack(input int d);
        logic [47:0] v;
        v = '0;
        for (int k = 0; k < 6; k++)
            v = le[d] ? {fw[d][k], v[47:8]} : {v[39:0], fw[d][k]};
        return v;
    endfunction

    function automatic void m_word(input int d, input logic [7:0] w, input longint c);
        int s;
        m_flush(d, c - 1);
        if (!in_frame[d]) begin
            if (w == 8'hA5) begin
                in_frame[d] = 1'b1;
                fcnt[d]     = 0;
                last_c[d]   = c;
            end
        end else if (fcnt[d] < 6) begin
            fw[d][fcnt[d]] = w;
            fcnt[d]++;
            last_c[d] = c;
        end else begin
            s = 0;
            for (int k = 0; k < 6; k++) s += int'(fw[d][k]);
            if (w == 8'(s)) begin
                good[d] = pack(d);
                push_exp(d, K_DV, c, good[d]);
            end else begin
                push_exp(d, K_CK, c, good[d]);
            end
            in_frame[d] = 1'b0;
        end
    endfunction

    function automatic void m_reset(input int d, input longint r);
        m_flush(d, r - 1);
        in_frame[d] = 1'b0;
        good[d]     = '0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_one(input int d, input logic [47:0] data, input logic dv,
                           input logic ce, input logic te, input logic busy);
        int   n;
        int   kind;
        exp_t e;
        n = int'(dv) + int'(ce) + int'(te);
        if (n == 0) return;
        chk($sformatf("u%0d_one_pulse", d), 64'(n), 64'd1);
        kind = dv ? K_DV : (ce ? K_CK : K_TO);
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk($sformatf("u%0d_unexpected_pulse", d), 64'(kind), 64'd0);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("u%0d_pulse_kind", d), 64'(kind), 64'(e.kind));
        chk($sformatf("u%0d_pulse_cycle", d), 64'(cyc), 64'(e.cyc));
        chk($sformatf("u%0d_o_data", d), 64'(data), 64'(e.data));
        chk($sformatf("u%0d_busy_after_pulse", d), 64'(busy), 64'd0);
    endtask

    always @(negedge clk) begin
        mon_one(0, o_data0, o_dv0, o_ck0, o_to0, o_busy0);
        mon_one(1, o_data1, o_dv1, o_ck1, o_to1, o_busy1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            m_flush(0, cyc);
            m_flush(1, cyc);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int hold, input int gap);
        longint c;
        c      = cyc + 1;
        i_data = w;
        i_dv   = 1'b1;
        m_word(0, w, c);
        m_word(1, w, c);
        tick(hold);
        i_dv = 1'b0;
        tick(gap);
    endtask

    task automatic send_frame(input bq_t f, input int hold, input int gap);
        foreach (f[i]) send_word(f[i], hold, gap);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        m_reset(0, cyc + 1);
        m_reset(1, cyc + 1);
        tick(3);
        i_reset = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t good_f, bad_f, hunt_f, f;
        int  stall_at, hold, gap, s;
        logic [7:0] b;

        for (int d = 0; d < 2; d++) begin
            in_frame[d] = 1'b0;
            fcnt[d]     = 0;
            last_c[d]   = 0;
            good[d]     = '0;
        end
        good_f = '{8'hA5, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h2E};
        bad_f  = '{8'hA5, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h2F};
        // Six A5 payload words sum to 0xDE modulo 256.
        hunt_f = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hDE};

        tick(2);
        do_reset();
        chk("rst_o_data0", 64'(o_data0), 64'd0);
        chk("rst_o_data1", 64'(o_data1), 64'd0);
        chk("rst_busy0", 64'(o_busy0), 64'd0);
        chk("rst_pulses0", 64'({o_dv0, o_ck0, o_to0}), 64'd0);

        // Good frame, 5-cycle i_dv
        send_word(8'hA5, 5, 1);
        chk("busy0_after_sync", 64'(o_busy0), 64'd1);
        chk("busy1_after_sync", 64'(o_busy1), 64'd1);
        for (int i = 1; i < 8; i++) send_word(good_f[i], 5, 1);
        tick(2);
        chk("good_be_data", 64'(o_data0), 64'h01030000002A);
        chk("good_le_data", 64'(o_data1), 64'h2A0000000301);

        // Bad checksum keeps previous data
        send_frame(bad_f, 5, 1);
        tick(2);
        chk("badck_hold_data", 64'(o_data0), 64'h01030000002A);

        // Sync hunt with in-band sync words
        send_frame(hunt_f, 2, 1);
        tick(2);
        chk("hunt_be_data", 64'(o_data0), 64'hA5A5A5A5A5A5);
        chk("hunt_le_data", 64'(o_data1), 64'hA5A5A5A5A5A5);

        // Timeout on the short-timeout instance only
        send_word(8'hA5, 2, 1);
        send_word(8'h01, 2, 1);
        send_word(8'h03, 2, 1);
        tick(60);
        chk("busy0_after_timeout", 64'(o_busy0), 64'd0);
        chk("busy1_still_in_frame", 64'(o_busy1), 64'd1);
        tick(1000);
        send_frame(good_f, 2, 1);
        tick(2);
        chk("post_timeout_be_data", 64'(o_data0), 64'h01030000002A);

        // Word arriving exactly on the expiry cycle is accepted
        foreach (good_f[i]) send_word(good_f[i], 1, 48);
        tick(2);
        chk("expiry_edge_be_data", 64'(o_data0), 64'h01030000002A);
        // One cycle later is too late
        send_word(8'hA5, 1, 49);
        for (int i = 1; i < 8; i++) send_word(good_f[i], 1, 1);
        tick(1100);

        // Reset one cycle after third payload word
        send_word(8'hA5, 1, 1);
        send_word(8'h01, 1, 1);
        send_word(8'h03, 1, 1);
        send_word(8'h00, 1, 0);
        do_reset();
        chk("midrst_o_data0", 64'(o_data0), 64'd0);
        chk("midrst_o_data1", 64'(o_data1), 64'd0);
        chk("midrst_busy1", 64'(o_busy1), 64'd0);

        // Long i_dv: one acceptance per high period
        send_frame(good_f, 200, 1);
        tick(2);
        chk("long_dv_le_data", 64'(o_data1), 64'h2A0000000301);

        // Randomized frames with noise, corrupt checksums and stalls
        for (int it = 0; it < 40; it++) begin
            f = {};
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                f.push_back(b);
            end
            f.push_back(8'hA5);
            s = 0;
            repeat (6) begin
                b = 8'($urandom);
                s += int'(b);
                f.push_back(b);
            end
            b = 8'(s);
            if ($urandom_range(0, 3) == 0) b = b ^ (8'h01 << $urandom_range(0, 7));
            f.push_back(b);
            hold     = int'($urandom_range(1, 4));
            gap      = int'($urandom_range(1, 3));
            stall_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, f.size() - 1)) : -1;
            foreach (f[i]) begin
                send_word(f[i], hold, gap);
                if (i == stall_at) tick(55);
            end
        end

        tick(1100);
        chk("u0_expected_drained", 64'(q0.size()), 64'd0);
        chk("u1_expected_drained", 64'(q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
